// File: rtl/sobel_linebuf_ctrl.sv
// Three-row line buffer sequencer for the Sobel kernel: drives two line FIFOs, emits column-aligned taps.
// Optional FIFO access checking is enabled with `define SOBEL_LBC_ERR_CHK_EN.
module sobel_linebuf_ctrl #(
  parameter int DW       = 8,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CW       = 12,
  parameter int RW       = 11
) (
  input  logic          clk,
  input  logic          tb_rst,
  input  logic          frame_start,
  input  logic          pix_vld,
  input  logic [DW-1:0] pix_data,
  output logic          fifo_clr,
  output logic          a_wr_en,
  output logic [DW-1:0] a_wr_data,
  output logic          a_rd_en,
  input  logic [DW-1:0] a_rd_data,
  output logic          b_wr_en,
  output logic [DW-1:0] b_wr_data,
  output logic          b_rd_en,
  input  logic [DW-1:0] b_rd_data,
  output logic [DW-1:0] tap0,
  output logic [DW-1:0] tap1,
  output logic [DW-1:0] tap2,
  output logic          out_vld,
  output logic          win_vld,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          frame_done,
  output logic          busy
`ifdef SOBEL_LBC_ERR_CHK_EN
  ,
  input  logic          a_full,
  input  logic          a_empty,
  input  logic          b_full,
  input  logic          b_empty,
  output logic [3:0]    err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ROW0, S_ROW1, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          acc;
  logic          last_col, last_row;

  logic          rd_a_q, rd_b_q, out_vld_q;
  logic [DW-1:0] tap2_q;
  logic [CW-1:0] out_col_q;
  logic [RW-1:0] out_row_q;

  assign last_col = (col_q == CW'(H_ACTIVE - 1));
  assign last_row = (row_q == RW'(V_ACTIVE - 1));

  // frame_start overrides everything, including a pixel in the same cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    acc     = 1'b0;
    if (frame_start) begin
      state_d = S_CLR;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        S_CLR:  state_d = S_ROW0;
        S_ROW0, S_ROW1, S_RUN: begin
          if (pix_vld) begin
            acc = 1'b1;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + RW'(1);
              if (state_q == S_ROW0)      state_d = S_ROW1;
              else if (state_q == S_ROW1) state_d = S_RUN;
              else if (last_row) begin
                state_d = S_DONE;
                row_d   = '0;
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign fifo_clr  = (state_q == S_CLR);
  assign a_wr_en   = acc;
  assign a_wr_data = pix_data;
  assign a_rd_en   = acc & ((state_q == S_ROW1) | (state_q == S_RUN));
  assign b_rd_en   = acc & (state_q == S_RUN);
  assign b_wr_en   = rd_a_q;
  assign b_wr_data = a_rd_data;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_a_q    <= 1'b0;
      rd_b_q    <= 1'b0;
      out_vld_q <= 1'b0;
      tap2_q    <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      rd_a_q    <= a_rd_en;
      rd_b_q    <= b_rd_en;
      out_vld_q <= acc;
      tap2_q    <= acc ? pix_data : '0;
      if (acc) begin
        out_col_q <= col_q;
        out_row_q <= row_q;
      end
    end
  end

  // FIFO read data is only meaningful the cycle after a read was issued
  assign tap0       = rd_b_q ? b_rd_data : '0;
  assign tap1       = rd_a_q ? a_rd_data : '0;
  assign tap2       = tap2_q;
  assign out_vld    = out_vld_q;
  assign win_vld    = out_vld_q & (out_row_q >= RW'(2));
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

`ifdef SOBEL_LBC_ERR_CHK_EN
  logic [3:0] err_q;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)                err_q <= '0;
    else if (state_q == S_CLR) err_q <= '0;
    else err_q <= err_q | {b_rd_en & b_empty, b_wr_en & b_full,
                           a_rd_en & a_empty, a_wr_en & a_full};
  end

  assign err = err_q;
`endif

endmodule
